// File: rtl/mac_sequencer.sv
// mac_sequencer: control FSM for a MAC datapath built from one-bit register banks.
// Runs a job of N multiply-accumulate terms: one CLEAR cycle, N ACCUM cycles, then
// holds DONE until ACK. Every output is a flop, so no input reaches an output
// combinationally.
module mac_sequencer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             START,
   input  logic [CNT_W-1:0] N_TERMS,
   input  logic             ABORT,
   input  logic             ACK,
   output logic             OP_LD,
   output logic [CNT_W-1:0] IDX,
   output logic             ACC_CLR,
   output logic             ACC_EN,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [1:0] {StIdle, StClear, StAccum, StDone} state_e;

   localparam logic [CNT_W-1:0] One = CNT_W'(1);
   localparam logic [CNT_W-1:0] Two = CNT_W'(2);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] n_q;
   logic             op_ld_q;
   logic [CNT_W-1:0] idx_q;
   logic             acc_clr_q;
   logic             acc_en_q;
   logic             busy_q;
   logic             done_q;

   // State, counter and outputs advance together; each output flop is loaded with
   // the value that belongs to the state being entered.
   always_ff @(posedge CLK) begin
      if (R) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         n_q       <= '0;
         op_ld_q   <= 1'b0;
         idx_q     <= '0;
         acc_clr_q <= 1'b0;
         acc_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         op_ld_q   <= 1'b0;
         idx_q     <= '0;
         acc_clr_q <= 1'b0;
         acc_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  state_q   <= StClear;
                  n_q       <= N_TERMS;
                  cnt_q     <= '0;
                  acc_clr_q <= 1'b1;
                  op_ld_q   <= (N_TERMS != '0);
                  busy_q    <= 1'b1;
               end
            end
            StClear: begin
               if (ABORT) begin
                  state_q <= StIdle;
               end else if (n_q == '0) begin
                  state_q <= StDone;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  // Entering ACCUM with k=0: operand 1 is loaded while term 0 is added.
                  state_q  <= StAccum;
                  acc_en_q <= 1'b1;
                  busy_q   <= 1'b1;
                  op_ld_q  <= (n_q > One);
                  idx_q    <= (n_q > One) ? One : '0;
               end
            end
            StAccum: begin
               if (ABORT) begin
                  state_q <= StIdle;
               end else if (cnt_q == n_q - One) begin
                  state_q <= StDone;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  // Next k is cnt_q+1; it loads operand k+1 while terms remain.
                  cnt_q    <= cnt_q + One;
                  acc_en_q <= 1'b1;
                  busy_q   <= 1'b1;
                  op_ld_q  <= ((cnt_q + One) < (n_q - One));
                  idx_q    <= ((cnt_q + One) < (n_q - One)) ? (cnt_q + Two) : '0;
               end
            end
            StDone: begin
               if (ACK) begin
                  state_q <= StIdle;
               end else begin
                  busy_q <= 1'b1;
                  done_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign OP_LD   = op_ld_q;
   assign IDX     = idx_q;
   assign ACC_CLR = acc_clr_q;
   assign ACC_EN  = acc_en_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule
